keycode_events: RTL
===================

KEYCODE_EVENTS -- requirements
Module: keycode_events

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles a keycode word must hold before it is accepted.
REQ-002 Parameter REPEAT_DELAY, default 50_000_000: cycles from a press event to the first repeat event.
REQ-003 Parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent repeat events.
REQ-004 Parameter FIFO_DEPTH, default 8: event queue depth; shall be a power of two.
REQ-005 Clk  input  1  single clock, 100 MHz, the same domain as the USB keycode GPIO.
REQ-006 reset_rtl_0  input  1  asynchronous, active-low reset.
REQ-007 keycode_i  input  32  four 8-bit USB HID keycodes; slot i is bits [8i+7:8i]; 8'h00 means an empty slot.
REQ-008 evt_valid  output  1  an event is at the queue head.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_code  output  8  keycode of the head event.
REQ-011 evt_repeat  output  1  head event is auto-repeat (1) or fresh press (0).
REQ-012 overflow  output  1  sticky flag: an event was dropped.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued events.

Function
REQ-014 keycode_i shall be registered once (kc_q) before any use.
REQ-015 kc_q shall be accepted into the snapshot register only after being unchanged for STABLE_CYCLES consecutive cycles while the FSM is in IDLE.
REQ-016 Any change in kc_q shall restart the stability count.
REQ-017 A word with any slot equal to 8'h01 (ErrorRollOver) shall never be accepted; the snapshot keeps its old value.
REQ-018 FSM states: IDLE and SCAN.
- IDLE->SCAN on acceptance.
- SCAN visits slots 0..3, one per cycle, then returns to IDLE.
REQ-019 In SCAN, slot i shall push a press event (repeat=0) iff all three hold:
- the code is nonzero;
- the code is absent from every slot of the previous snapshot;
- the code does not also appear in a lower-numbered slot of the new snapshot.
REQ-020 Timing for a single new key in slot 0 with keycode_i stable: evt_valid shall rise exactly STABLE_CYCLES+3 cycles after keycode_i changes; slot i adds i cycles.
REQ-021 Key releases shall produce no events.
REQ-022 Repeat tracking target: the code of the most recent press event.
- The repeat timer is loaded on every press event.
- It counts only in IDLE.
REQ-023 The repeat timer shall fire a repeat event (repeat=1) REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
REQ-024 The repeat target shall be cleared when its code is absent from a newly accepted snapshot; no repeat may fire after that.
REQ-025 FIFO behaviour:
- show-ahead;
- evt_valid = (fifo_count != 0);
- pop on evt_valid && evt_ready;
- evt_code and evt_repeat stable while evt_valid && !evt_ready.
REQ-026 A push when fifo_count==FIFO_DEPTH and no pop in the same cycle shall be dropped and shall set overflow.
- Push and pop in the same cycle at full shall both succeed.
- Push and pop in the same cycle at empty shall leave fifo_count at 0 only after the pushed event is delivered; the pushed event is visible next cycle.
REQ-027 fifo_count shall never exceed FIFO_DEPTH and shall not wrap.

Reset
REQ-028 While reset_rtl_0=0, all of the following shall hold:
- evt_valid=0, evt_code=0, evt_repeat=0, overflow=0, fifo_count=0;
- snapshot and kc_q all zero;
- FSM in IDLE;
- repeat target cleared.
REQ-029 Reset mid-SCAN or with a non-empty FIFO shall discard all pending events.
REQ-030 Keys held through reset release shall generate fresh press events, because the snapshot restarts at zero.
REQ-031 overflow shall be cleared only by reset.

Structure
REQ-032 Package keycode_pkg shall hold:
- keycode_t (8 bits);
- state_e {IDLE, SCAN};
- key_event_t struct {repeat, code};
- constants HID_NONE=8'h00 and HID_ERR_ROLLOVER=8'h01.
REQ-033 The queue shall be a separate sub-module, event_fifo, parameterised by depth and carrying key_event_t.

Verification
REQ-034 (Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, FIFO_DEPTH=4, evt_ready=1 unless stated.)
- keycode_i 0 -> 32'h0000_0004 -> single event code=8'h04, repeat=0, with evt_valid rising 7 cycles after the change.
- keycode_i 32'h0000_0004 -> 32'h0005_0604 -> events 8'h06, then 8'h05, on consecutive cycles; none for 8'h04.
- 32'h0000_0004 held 40 cycles after its press -> repeats at press+20 and press+25, and so on; driving 0 stops further repeats.
- evt_ready=0 with 6 distinct keys pressed in sequence -> fifo_count saturates at 4 and overflow=1; draining yields the first 4 codes in order.
- keycode_i toggling every 2 cycles, or any slot = 8'h01 -> no events.
- reset_rtl_0 pulsed low mid-SCAN while 8'h04 stays held -> all outputs 0 during reset; one press event for 8'h04 after release.

Source files
------------

// File: rtl/keycode_pkg.sv
// Shared types and helpers for the keycode event block.
//   keycode_t   : one USB HID keycode (8 bits)
//   keyword_t   : four keycode slots packed as slot i = bits [8i+7:8i]
//   state_e     : scanner FSM states
//   key_event_t : queued event (auto-repeat flag + keycode)
//   HID_NONE / HID_ERR_ROLLOVER : reserved keycodes
package keycode_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [7:0] keycode_t;
  typedef logic [NUM_SLOTS*8-1:0] keyword_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef struct packed {
    logic     is_repeat;
    keycode_t code;
  } key_event_t;

  localparam keycode_t HID_NONE         = 8'h00;
  localparam keycode_t HID_ERR_ROLLOVER = 8'h01;

  // Keycode held in slot idx of a word.
  function automatic keycode_t slot_code(keyword_t w, logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // True when any slot of w holds code.
  function automatic logic word_has(keyword_t w, keycode_t code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w[8*i +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when code already sits in a slot numbered below idx, so a
  // duplicated key only produces one press event.
  function automatic logic in_lower_slot(keyword_t w, logic [1:0] idx, keycode_t code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((2'(i) < idx) && (w[8*i +: 8] == code)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead event queue.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, push_data : enqueue request (dropped when full and not popping)
//   pop_ready    : consumer ready
//   valid, head  : queue head (head forced to zero while empty)
//   overflow     : sticky, set when a push is dropped; cleared only by reset
//   count        : number of queued events, 0..DEPTH
// Handshake: valid is high whenever count != 0; the head is consumed on a
// cycle where valid && pop_ready, and head holds steady while valid && !pop_ready.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module event_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  key_event_t               push_data,
  input  logic                     pop_ready,
  output logic                     valid,
  output key_event_t               head,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push_ok;
  logic          full;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = valid && pop_ready;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign push_ok = push && (!full || pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keycode_events.sv
// Turns the four-slot USB HID keycode word into a stream of key events.
// The word is registered, debounced (must hold STABLE_CYCLES cycles), then
// compared slot by slot against the previously accepted snapshot; every
// newly appearing key becomes a press event. The most recently pressed key
// auto-repeats after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//   Clk, reset_rtl_0 : clock, asynchronous active-low reset
//   keycode_i        : four 8-bit keycodes, slot i = bits [8i+7:8i]
//   evt_valid/evt_ready/evt_code/evt_repeat : event queue head handshake
//   overflow         : sticky, an event was dropped at a full queue
//   fifo_count       : number of queued events
//   dbg_state        : scanner FSM state
// REPEAT_DELAY must be at least 4 (the scan length).
module keycode_events
  import keycode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                         Clk,
  input  logic                         reset_rtl_0,
  input  logic [31:0]                  keycode_i,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [7:0]                   evt_code,
  output logic                         evt_repeat,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output state_e                       dbg_state
);

  localparam int CW      = $clog2(STABLE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(RPT_MAX + 1);

  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  // The timer only runs in IDLE, so a press in slot s is loaded short by the
  // (NUM_SLOTS-1-s) scan cycles still to come; the first repeat then lands
  // exactly REPEAT_DELAY cycles after the press.
  localparam logic [TW-1:0] DELAY_BASE = TW'(REPEAT_DELAY - (NUM_SLOTS - 1));
  localparam logic [TW-1:0] PERIOD_LD  = TW'(REPEAT_PERIOD);

  keyword_t      kc_q;
  keyword_t      snap;
  keyword_t      prev_snap;
  logic [CW-1:0] stab_cnt;

  state_e        state, state_n;
  logic [1:0]    slot, slot_n;

  logic          rpt_valid;
  keycode_t      rpt_code;
  logic [TW-1:0] rpt_timer;

  logic          accept;
  keycode_t      scan_code;
  logic          press;
  logic          rpt_fire;
  logic          push;
  key_event_t    push_data;
  key_event_t    head;

  // Input register and stability counter. The counter restarts whenever
  // kc_q is about to change and saturates at STABLE_CYCLES.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      kc_q     <= '0;
      stab_cnt <= '0;
    end else begin
      kc_q <= keycode_i;
      if (keycode_i != kc_q)        stab_cnt <= '0;
      else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Accept a stable, different, rollover-free word; an identical word would
  // only rescan and disturb the repeat timer.
  assign accept = (state == IDLE) && (stab_cnt == STABLE_MAX) &&
                  (kc_q != snap) && !word_has(kc_q, HID_ERR_ROLLOVER);

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      snap      <= '0;
      prev_snap <= '0;
    end else if (accept) begin
      snap      <= kc_q;
      prev_snap <= snap;
    end
  end

  // Scanner FSM: state register.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  // Scanner FSM: next state. SCAN walks slots 0..3, one per cycle.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SCAN;
          slot_n  = 2'd0;
        end
      end
      SCAN: begin
        slot_n = slot + 2'd1;
        if (slot == 2'(NUM_SLOTS - 1)) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        slot_n  = 2'd0;
      end
    endcase
  end

  assign dbg_state = state;
  assign scan_code = slot_code(snap, slot);
  assign press     = (state == SCAN) && (scan_code != HID_NONE) &&
                     !word_has(prev_snap, scan_code) &&
                     !in_lower_slot(snap, slot, scan_code);
  assign rpt_fire  = (state == IDLE) && rpt_valid && (rpt_timer == TW'(1));

  // Repeat target tracking. Presses happen only in SCAN and repeats only in
  // IDLE, so at most one event is pushed per cycle.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      rpt_valid <= 1'b0;
      rpt_code  <= HID_NONE;
      rpt_timer <= '0;
    end else if (accept && !word_has(kc_q, rpt_code)) begin
      rpt_valid <= 1'b0;
    end else if (press) begin
      rpt_valid <= 1'b1;
      rpt_code  <= scan_code;
      rpt_timer <= DELAY_BASE + TW'(slot);
    end else if (rpt_fire) begin
      rpt_timer <= PERIOD_LD;
    end else if ((state == IDLE) && rpt_valid) begin
      rpt_timer <= rpt_timer - 1'b1;
    end
  end

  always_comb begin
    push_data = '0;
    push      = press || rpt_fire;
    if (press) begin
      push_data.is_repeat = 1'b0;
      push_data.code      = scan_code;
    end else if (rpt_fire) begin
      push_data.is_repeat = 1'b1;
      push_data.code      = rpt_code;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (reset_rtl_0),
    .push      (push),
    .push_data (push_data),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .head      (head),
    .overflow  (overflow),
    .count     (fifo_count)
  );

  assign evt_code   = head.code;
  assign evt_repeat = head.is_repeat;

endmodule
